// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry stage: key codes,
// FSM state encodings and key classification helpers.
package calc_pkg;

  // Key codes delivered by the keypad scanner
  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hC;
  localparam logic [3:0] KEY_CLR   = 4'hD;

  // FSM state encodings (encoding 3 is illegal)
  localparam logic [1:0] ENTER_A = 2'd0;
  localparam logic [1:0] ENTER_B = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;

  // Decoded key class; KC_NONE covers "no strobe" and reserved codes
  typedef enum logic [2:0] {
    KC_NONE,
    KC_DIGIT,
    KC_OP,
    KC_EQ,
    KC_CLR
  } key_class_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code < 4'd10;
  endfunction

  function automatic key_class_e classify_key(input logic valid, input logic [3:0] code);
    if (!valid)                                  return KC_NONE;
    if (is_digit(code))                          return KC_DIGIT;
    if (code == KEY_PLUS || code == KEY_MINUS)   return KC_OP;
    if (code == KEY_EQ)                          return KC_EQ;
    if (code == KEY_CLR)                         return KC_CLR;
    return KC_NONE;
  endfunction

endpackage

// File: rtl/calc_entry_shift.sv
// NDIG-digit packed-BCD shift register with a saturating digit counter.
// clear and load_digit may be asserted together: the register restarts
// holding just the new digit. load_word replaces the whole value and
// marks all digits as entered.
module calc_entry_shift #(
  parameter int NDIG = 4,
  localparam int W  = 4 * NDIG,
  localparam int CW = $clog2(NDIG + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_digit,
  input  logic [3:0]    digit,
  input  logic          load_word,
  input  logic [W-1:0]  word,
  output logic [W-1:0]  value,
  output logic [CW-1:0] cnt
);

  logic [W-1:0]  val_q, val_d, base_val;
  logic [CW-1:0] cnt_q, cnt_d, base_cnt;

  // Next value: optional clear, then a word load or a saturating digit shift
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    base_val = clear ? '0 : val_q;
    base_cnt = clear ? '0 : cnt_q;
    val_d    = base_val;
    cnt_d    = base_cnt;
    if (load_word) begin
      val_d = word;
      cnt_d = CW'(NDIG);
    end else if (load_digit && (base_cnt < CW'(NDIG))) begin
      val_d = {base_val[W-5:0], digit};
      cnt_d = base_cnt + CW'(1);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign value = val_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/calc_entry.sv
// Operand-entry stage for the BCD add/subtract ALU. Turns keypad events
// into two packed-BCD operands, an operation select and a go pulse, and
// selects what the display shows.
// Optional feature: define CALC_CHAIN_EN for chained calculations
// (operator key after a result reuses alu_res as operand A).
module calc_entry
  import calc_pkg::*;
#(
  parameter int NDIG = 4,
  localparam int W  = 4 * NDIG,
  localparam int CW = $clog2(NDIG + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic [W-1:0] alu_res,
  input  logic         alu_ovf,
  input  logic         alu_sign,
  output logic [W-1:0] reg1,
  output logic [W-1:0] reg2,
  output logic         regop,
  output logic         go,
  output logic [W-1:0] disp,
  output logic [1:0]   state_o
);

  logic [1:0]    state_q, state_d;
  logic          regop_q, regop_d;
  logic          go_q, go_d;
  logic          a_clear, a_load_digit, a_load_word;
  logic          b_clear, b_load_digit;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          do_reset, key_plus;
  key_class_e    kc;

`ifdef CALC_CHAIN_EN
  logic pend_q, pend_d;
  logic pend_op_q, pend_op_d;
`else
  logic unused_flags;
  assign unused_flags = alu_ovf ^ alu_sign;
`endif

  assign kc       = classify_key(key_valid, key_code);
  assign key_plus = (key_code == KEY_PLUS);
  assign do_reset = (kc == KC_CLR) || (state_q == 2'd3);

  calc_entry_shift #(.NDIG(NDIG)) u_reg_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (a_clear),
    .load_digit (a_load_digit),
    .digit      (key_code),
    .load_word  (a_load_word),
    .word       (alu_res),
    .value      (reg1),
    .cnt        (cnt_a)
  );

  calc_entry_shift #(.NDIG(NDIG)) u_reg_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (b_clear),
    .load_digit (b_load_digit),
    .digit      (key_code),
    .load_word  (1'b0),
    .word       ('0),
    .value      (reg2),
    .cnt        (cnt_b)
  );

  // Entry FSM: decode the current key against the state
  always_comb begin
    state_d      = state_q;
    regop_d      = regop_q;
    go_d         = 1'b0;
    a_clear      = 1'b0;
    a_load_digit = 1'b0;
    a_load_word  = 1'b0;
    b_clear      = 1'b0;
    b_load_digit = 1'b0;
`ifdef CALC_CHAIN_EN
    pend_d       = 1'b0;
    pend_op_d    = pend_op_q;
`endif
    if (do_reset) begin
      // Clear key or illegal state: everything back to reset values
      state_d = ENTER_A;
      regop_d = 1'b1;
      a_clear = 1'b1;
      b_clear = 1'b1;
`ifdef CALC_CHAIN_EN
    end else if (pend_q) begin
      // Second half of "= then op": result becomes operand A
      if (!(alu_ovf || alu_sign)) begin
        a_load_word = 1'b1;
        b_clear     = 1'b1;
        regop_d     = pend_op_q;
        state_d     = ENTER_B;
      end
`endif
    end else begin
      case (state_q)
        ENTER_A: begin
          if (kc == KC_DIGIT) begin
            a_load_digit = 1'b1;
          end else if (kc == KC_OP) begin
            regop_d = key_plus;
            b_clear = 1'b1;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (kc == KC_DIGIT) begin
            b_load_digit = 1'b1;
          end else if (kc == KC_OP) begin
            if (cnt_b == '0) begin
              regop_d = key_plus;
            end
`ifdef CALC_CHAIN_EN
            else begin
              go_d      = 1'b1;
              pend_d    = 1'b1;
              pend_op_d = key_plus;
              state_d   = RESULT;
            end
`endif
          end else if (kc == KC_EQ) begin
            go_d    = 1'b1;
            state_d = RESULT;
          end
        end
        RESULT: begin
          if (kc == KC_DIGIT) begin
            a_clear      = 1'b1;
            a_load_digit = 1'b1;
            b_clear      = 1'b1;
            regop_d      = 1'b1;
            state_d      = ENTER_A;
          end else if (kc == KC_OP) begin
`ifdef CALC_CHAIN_EN
            if (!(alu_ovf || alu_sign)) begin
              a_load_word = 1'b1;
              regop_d     = key_plus;
              b_clear     = 1'b1;
              state_d     = ENTER_B;
            end
`else
            regop_d = key_plus;
            b_clear = 1'b1;
            state_d = ENTER_B;
`endif
          end else if (kc == KC_EQ) begin
            go_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTER_A;
      regop_q <= 1'b1;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      regop_q <= regop_d;
      go_q    <= go_d;
    end
  end

`ifdef CALC_CHAIN_EN
  // Pending chained-operation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= 1'b0;
      pend_op_q <= 1'b1;
    end else begin
      pend_q    <= pend_d;
      pend_op_q <= pend_op_d;
    end
  end
`endif

  // Display source select
  always_comb begin
    disp = reg1;
    case (state_q)
      ENTER_B: disp = (cnt_b != '0) ? reg2 : reg1;
      RESULT:  disp = alu_res;
      default: disp = reg1;
    endcase
  end

  assign regop   = regop_q;
  assign go      = go_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_calc_entry.sv
// Self-checking bench for calc_entry. Directed key sequences; expected
// operand sets are queued when "=" is pressed and compared when go pulses.
// Define CALC_CHAIN_EN to exercise the chained-calculation feature.
module tb_calc_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_res;
  logic        alu_ovf;
  logic        alu_sign;
  logic [15:0] reg1, reg2, disp;
  logic        regop, go;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r1;
    logic [15:0] r2;
    logic        op;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  calc_entry #(.NDIG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .alu_res   (alu_res),
    .alu_ovf   (alu_ovf),
    .alu_sign  (alu_sign),
    .reg1      (reg1),
    .reg2      (reg2),
    .regop     (regop),
    .go        (go),
    .disp      (disp),
    .state_o   (state_o)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One key strobe, then one idle cycle; returns on a falling edge
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic push_exp(input logic [15:0] r1, input logic [15:0] r2, input logic op);
    exp_t e;
    e.r1 = r1;
    e.r2 = r2;
    e.op = op;
    sb.push_back(e);
  endtask

  // Scoreboard: every go pulse must match the oldest queued operand set
  always @(negedge clk) begin
    if (go === 1'b1) begin
      if (sb.size() == 0) begin
        check("go_unexpected", 16'(go), 16'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_reg1", reg1, e.r1);
        check("sb_reg2", reg2, e.r2);
        check("sb_regop", 16'(regop), 16'(e.op));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    alu_res   = 16'h0000;
    alu_ovf   = 1'b0;
    alu_sign  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_reg1", reg1, 16'h0000);
    check("rst_reg2", reg2, 16'h0000);
    check("rst_regop", 16'(regop), 16'h1);
    check("rst_go", 16'(go), 16'h0);
    check("rst_state", 16'(state_o), 16'h0);

    // Two digits into operand A
    press(4'h1); press(4'h2);
    check("a12_reg1", reg1, 16'h0012);
    check("a12_disp", disp, 16'h0012);
    check("a12_state", 16'(state_o), 16'h0);
    check("a12_go", 16'(go), 16'h0);

    // Saturation at four digits
    press(4'hD);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    check("sat4_reg1", reg1, 16'h9876);
    press(4'h5);
    check("sat5_reg1", reg1, 16'h9876);

    // 10 + 21 =
    press(4'hD);
    press(4'h1); press(4'h0); press(4'hA);
    check("op_state", 16'(state_o), 16'h1);
    check("op_disp_a", disp, 16'h0010);
    press(4'h2); press(4'h1);
    check("b_disp", disp, 16'h0021);
    alu_res = 16'h0031;
    push_exp(16'h0010, 16'h0021, 1'b1);
    press(4'hC);
    check("eq_go", 16'(go), 16'h1);
    check("eq_state", 16'(state_o), 16'h2);
    check("eq_disp", disp, 16'h0031);
    @(negedge clk);
    check("eq_go_drop", 16'(go), 16'h0);

    // New calculation from RESULT, operator correction
    press(4'h8);
    check("new_reg1", reg1, 16'h0008);
    check("new_state", 16'(state_o), 16'h0);
    press(4'hB);
    check("minus_regop", 16'(regop), 16'h0);
    press(4'hA);
    check("corr_regop", 16'(regop), 16'h1);
    press(4'h3);
    check("corr_reg2", reg2, 16'h0003);
    push_exp(16'h0008, 16'h0003, 1'b1);
    press(4'hC);
    press(4'h5);
    check("restart_reg1", reg1, 16'h0005);
    check("restart_reg2", reg2, 16'h0000);
    check("restart_state", 16'(state_o), 16'h0);

    // "=" in ENTER_A and reserved codes are ignored
    press(4'hC);
    check("eqA_state", 16'(state_o), 16'h0);
    check("eqA_go", 16'(go), 16'h0);
    press(4'hE);
    check("rsv_reg1", reg1, 16'h0005);

`ifndef CALC_CHAIN_EN
    // Op after digits in ENTER_B ignored; repeated "="; reuse of operand A
    press(4'hA); press(4'h2);
    press(4'hB);
    check("bop_regop", 16'(regop), 16'h1);
    check("bop_state", 16'(state_o), 16'h1);
    push_exp(16'h0005, 16'h0002, 1'b1);
    press(4'hC);
    push_exp(16'h0005, 16'h0002, 1'b1);
    press(4'hC);
    check("rep_go", 16'(go), 16'h1);
    check("rep_state", 16'(state_o), 16'h2);
    press(4'hB);
    check("reuse_reg1", reg1, 16'h0005);
    check("reuse_reg2", reg2, 16'h0000);
    check("reuse_regop", 16'(regop), 16'h0);
    check("reuse_state", 16'(state_o), 16'h1);
`endif

    // Clear mid-entry
    press(4'hD);
    press(4'h4); press(4'hA); press(4'h2);
    press(4'hD);
    check("clr_reg1", reg1, 16'h0000);
    check("clr_reg2", reg2, 16'h0000);
    check("clr_regop", 16'(regop), 16'h1);
    check("clr_state", 16'(state_o), 16'h0);
    check("clr_disp", disp, 16'h0000);

    // rst while go is high
    press(4'h1); press(4'hB); press(4'h2);
    push_exp(16'h0001, 16'h0002, 1'b0);
    press(4'hC);
    check("rstgo_go_hi", 16'(go), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstgo_go", 16'(go), 16'h0);
    check("rstgo_reg1", reg1, 16'h0000);
    check("rstgo_reg2", reg2, 16'h0000);
    check("rstgo_regop", 16'(regop), 16'h1);
    check("rstgo_state", 16'(state_o), 16'h0);

`ifdef CALC_CHAIN_EN
    // 5 + 3 = (8), then + 2 = chains from the result
    press(4'h5); press(4'hA); press(4'h3);
    alu_res = 16'h0008;
    push_exp(16'h0005, 16'h0003, 1'b1);
    press(4'hC);
    press(4'hA);
    check("ch_reg1", reg1, 16'h0008);
    check("ch_state", 16'(state_o), 16'h1);
    press(4'h2);
    check("ch_reg2", reg2, 16'h0002);
    push_exp(16'h0008, 16'h0002, 1'b1);
    press(4'hC);
    // Negative result blocks chaining
    alu_sign = 1'b1;
    press(4'hB);
    check("neg_state", 16'(state_o), 16'h2);
    check("neg_reg1", reg1, 16'h0008);
    alu_sign = 1'b0;
    // Op with digits in ENTER_B acts as "=" then op
    press(4'hD);
    press(4'h4); press(4'hA); press(4'h1);
    alu_res = 16'h0005;
    push_exp(16'h0004, 16'h0001, 1'b1);
    press(4'hB);
    check("eqop_go", 16'(go), 16'h1);
    @(negedge clk);
    check("eqop_reg1", reg1, 16'h0005);
    check("eqop_reg2", reg2, 16'h0000);
    check("eqop_regop", 16'(regop), 16'h0);
    check("eqop_state", 16'(state_o), 16'h1);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
